// File: rtl/ir_rx_decoder_if.sv
// ---------------------------------------------------------------------------
// ir_rx_decoder_if
//   Output bundle of the IR receive decoder.
//   Dout       - last correctly received byte (held until the next good frame)
//   data_valid - one-cycle pulse in the cycle Dout is updated
//   frame_err  - one-cycle pulse when a stop bit is received as mark
//   busy       - high while a frame is being decoded
//   master: the decoder (drives everything); slave: the consuming logic.
// ---------------------------------------------------------------------------
interface ir_rx_decoder_if;
   logic [7:0] Dout;
   logic       data_valid;
   logic       frame_err;
   logic       busy;

   modport master (output Dout, output data_valid, output frame_err, output busy);
   modport slave  (input  Dout, input  data_valid, input  frame_err, input  busy);
endinterface

// File: rtl/ir_rx_decoder.sv
// ---------------------------------------------------------------------------
// ir_rx_decoder
//   Decodes one UART-like frame from the demodulated IR receiver output:
//   start (mark), 8 data bits LSB first (mark = 1), stop (space).
//   Each bit lasts BIT_CYCLES clocks; bits are sampled at mid-bit.
//
// Ports:
//   CLK_50M   in   system clock
//   reset     in   synchronous active-high reset
//   IRDA_RXD  in   asynchronous receiver output, 0 = carrier (mark)
//   rx        out  ir_rx_decoder_if.master: Dout, data_valid, frame_err, busy
// ---------------------------------------------------------------------------
module ir_rx_decoder #(
   parameter int BIT_CYCLES  = 41667,
   parameter int HALF_CYCLES = BIT_CYCLES / 2
) (
   input  logic               CLK_50M,
   input  logic               reset,
   input  logic               IRDA_RXD,
   ir_rx_decoder_if.master    rx
);

   localparam int CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYCLES - 1);
   localparam logic [CW-1:0] HALF_LAST = CW'(HALF_CYCLES - 1);

   localparam logic [2:0] IDLE      = 3'd0;
   localparam logic [2:0] START     = 3'd1;
   localparam logic [2:0] DATA      = 3'd2;
   localparam logic [2:0] STOP      = 3'd3;
   localparam logic [2:0] WAIT_IDLE = 3'd4;

   // Synchroniser resets to space so reset never looks like a start edge.
   logic          sync1_q, sync2_q;
   logic          mark;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [2:0]    bidx_q, bidx_d;
   logic [7:0]    sr_q, sr_d;
   logic [7:0]    dout_q, dout_d;
   logic          dv_q, dv_d;
   logic          ferr_q, ferr_d;

   assign mark = ~sync2_q;

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      bidx_d  = bidx_q;
      sr_d    = sr_q;
      dout_d  = dout_q;
      dv_d    = 1'b0;
      ferr_d  = 1'b0;

      case (state_q)
         IDLE: begin
            if (mark) begin
               cnt_d   = '0;
               state_d = START;
            end
         end

         START: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HALF_LAST) begin
               if (mark) begin
                  // Start bit confirmed at its middle; all later samples
                  // land one full bit period apart, i.e. mid-bit.
                  cnt_d   = '0;
                  bidx_d  = '0;
                  state_d = DATA;
               end else begin
                  state_d = IDLE;
               end
            end
         end

         DATA: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BIT_LAST) begin
               sr_d  = {mark, sr_q[7:1]};
               cnt_d = '0;
               if (bidx_q == 3'd7) begin
                  state_d = STOP;
               end else begin
                  bidx_d = bidx_q + 1'b1;
               end
            end
         end

         STOP: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == BIT_LAST) begin
               cnt_d = '0;
               if (!mark) begin
                  dout_d  = sr_q;
                  dv_d    = 1'b1;
                  // Leaving at mid-stop-bit lets a back-to-back start edge
                  // be caught at the nominal stop-bit end.
                  state_d = IDLE;
               end else begin
                  ferr_d  = 1'b1;
                  state_d = WAIT_IDLE;
               end
            end
         end

         WAIT_IDLE: begin
            // A stuck mark must not be mistaken for a new start bit.
            if (!mark) begin
               state_d = IDLE;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK_50M) begin
      if (reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         state_q <= IDLE;
         cnt_q   <= '0;
         bidx_q  <= '0;
         sr_q    <= '0;
         dout_q  <= '0;
         dv_q    <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         sync1_q <= IRDA_RXD;
         sync2_q <= sync1_q;
         state_q <= state_d;
         cnt_q   <= cnt_d;
         bidx_q  <= bidx_d;
         sr_q    <= sr_d;
         dout_q  <= dout_d;
         dv_q    <= dv_d;
         ferr_q  <= ferr_d;
      end
   end

   assign rx.Dout       = dout_q;
   assign rx.data_valid = dv_q;
   assign rx.frame_err  = ferr_q;
   assign rx.busy       = (state_q != IDLE);

endmodule

// File: tb/tb_ir_rx_decoder.sv
module tb_ir_rx_decoder;

   localparam int BC = 16;

   logic clk = 1'b0;
   logic reset;
   logic irda;

   ir_rx_decoder_if rx_if ();

   ir_rx_decoder #(.BIT_CYCLES(BC)) dut (
      .CLK_50M  (clk),
      .reset    (reset),
      .IRDA_RXD (irda),
      .rx       (rx_if)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int passes = 0;
   int cyc = 0;
   int start_cyc = 0;
   int dv_cnt = 0;
   int fe_cnt = 0;
   logic dv_prev = 1'b0;
   logic [7:0] exp_q[$];

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input bit ok, input int act, input int exp);
      checks++;
      if (ok) passes++;
      else $display("FAIL %s: got 0x%0h (%0d), expected 0x%0h (%0d)", name, act, act, exp, exp);
   endtask

   task automatic chk_eq(input string name, input int act, input int exp);
      chk(name, act == exp, act, exp);
   endtask

   // Monitor / scoreboard: sampled 1 time unit after each rising edge.
   always begin
      @(posedge clk);
      #1;
      if (rx_if.data_valid || rx_if.frame_err)
         chk("dv_fe_exclusive", !(rx_if.data_valid && rx_if.frame_err),
             {rx_if.data_valid, rx_if.frame_err}, 0);
      if (rx_if.frame_err) fe_cnt++;
      if (rx_if.data_valid) begin
         int lat;
         logic [7:0] exp_b;
         dv_cnt++;
         lat = cyc - start_cyc;
         chk("dv_width", !dv_prev, int'(dv_prev), 0);
         if (exp_q.size() == 0) begin
            chk("dv_unexpected", 1'b0, int'(rx_if.Dout), -1);
         end else begin
            exp_b = exp_q.pop_front();
            chk_eq("dout", int'(rx_if.Dout), int'(exp_b));
            chk("latency", (lat >= 154) && (lat <= 156), lat, 155);
            $display("rx byte 0x%02h expected 0x%02h latency %0d", rx_if.Dout, exp_b, lat);
         end
      end
      dv_prev = rx_if.data_valid;
   end

   // All driving happens on the falling edge; tasks start and end there.
   task automatic hold(input logic v, input int n);
      irda = v;
      repeat (n) @(negedge clk);
   endtask

   // Start bit + data bits. abort_bit >= 0 stops half way through that bit.
   task automatic send_head(input logic [7:0] b, input int abort_bit);
      start_cyc = cyc;
      hold(1'b0, BC);
      for (int i = 0; i < 8; i++) begin
         if (i == abort_bit) begin
            hold(~b[i], BC / 2);
            return;
         end
         hold(~b[i], BC);
      end
   endtask

   task automatic send_frame(input logic [7:0] b);
      send_head(b, -1);
      hold(1'b1, BC);
   endtask

   typedef struct {
      logic [7:0] data;
      int         gap;
   } vec_t;

   vec_t vecs[5];

   initial begin
      int dv0, fe0;

      vecs[0] = '{8'hA5, 10};
      vecs[1] = '{8'h00, 0};   // back-to-back with the next one
      vecs[2] = '{8'hFF, 10};
      vecs[3] = '{8'h01, 5};
      vecs[4] = '{8'h80, 10};

      reset = 1'b1;
      irda  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk_eq("reset_dout", int'(rx_if.Dout), 0);
      chk_eq("reset_dv", int'(rx_if.data_valid), 0);
      chk_eq("reset_fe", int'(rx_if.frame_err), 0);
      chk_eq("reset_busy", int'(rx_if.busy), 0);
      @(negedge clk);
      reset = 1'b0;
      hold(1'b1, 10);

      // Table-driven good frames.
      for (int i = 0; i < 5; i++) begin
         dv0 = dv_cnt;
         fe0 = fe_cnt;
         exp_q.push_back(vecs[i].data);
         send_frame(vecs[i].data);
         chk_eq("frame_busy_done", int'(rx_if.busy), 0);
         chk_eq("frame_dv_count", dv_cnt - dv0, 1);
         chk_eq("frame_fe_count", fe_cnt - fe0, 0);
         chk_eq("frame_dout", int'(rx_if.Dout), int'(vecs[i].data));
         hold(1'b1, vecs[i].gap);
      end

      // Short mark glitch on an idle line.
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      hold(1'b0, 4);
      chk_eq("glitch_busy_high", int'(rx_if.busy), 1);
      hold(1'b1, BC / 2);
      chk_eq("glitch_busy_low", int'(rx_if.busy), 0);
      hold(1'b1, 12);
      chk_eq("glitch_dv", dv_cnt - dv0, 0);
      chk_eq("glitch_fe", fe_cnt - fe0, 0);
      chk_eq("glitch_dout", int'(rx_if.Dout), 8'h80);

      // Stop bit held as mark for 40 cycles.
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_head(8'h3C, -1);
      hold(1'b0, 39);
      chk_eq("stuck_busy", int'(rx_if.busy), 1);
      chk_eq("stuck_fe", fe_cnt - fe0, 1);
      chk_eq("stuck_dv", dv_cnt - dv0, 0);
      chk_eq("stuck_dout", int'(rx_if.Dout), 8'h80);
      hold(1'b0, 1);
      hold(1'b1, BC);
      chk_eq("stuck_release_busy", int'(rx_if.busy), 0);
      $display("stuck stop bit on 0x3C: frame_err pulses %0d", fe_cnt - fe0);
      exp_q.push_back(8'h81);
      send_frame(8'h81);
      chk_eq("after_stuck_dout", int'(rx_if.Dout), 8'h81);
      hold(1'b1, 10);

      // Reset in the middle of data bit 4.
      dv0 = dv_cnt;
      fe0 = fe_cnt;
      send_head(8'h5A, 4);
      chk_eq("midframe_busy", int'(rx_if.busy), 1);
      reset = 1'b1;
      irda  = 1'b1;
      @(posedge clk);
      #1;
      chk_eq("midreset_dout", int'(rx_if.Dout), 0);
      chk_eq("midreset_dv", int'(rx_if.data_valid), 0);
      chk_eq("midreset_fe", int'(rx_if.frame_err), 0);
      chk_eq("midreset_busy", int'(rx_if.busy), 0);
      $display("reset applied during bit 4 of 0x5A");
      @(negedge clk);
      reset = 1'b0;
      hold(1'b1, 3 * BC);
      chk_eq("midreset_no_dv", dv_cnt - dv0, 0);
      chk_eq("midreset_no_fe", fe_cnt - fe0, 0);
      chk_eq("midreset_idle", int'(rx_if.busy), 0);
      exp_q.push_back(8'h5A);
      send_frame(8'h5A);
      chk_eq("after_reset_dout", int'(rx_if.Dout), 8'h5A);
      hold(1'b1, 30);

      chk_eq("scoreboard_empty", exp_q.size(), 0);
      chk_eq("total_dv", dv_cnt, 7);
      chk_eq("total_fe", fe_cnt, 1);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule

// File: doc/ir_rx_decoder.md
Name: ir_rx_decoder

Overview:
- Receive-side counterpart of the IR transmit path.
- Takes the demodulated output of the IR receiver module (IRDA_RXD), decodes one 8-bit frame and presents the byte with a one-cycle valid strobe.
- The frame format is the one the transmit controller emits (Dout gated with the 38 kHz carrier).
- Sits between the IRDA_RXD pin and user logic (LEDs/HEX display) on the 50 MHz board clock.

Parameters:
- BIT_CYCLES, 41667, CLK_50M cycles per bit (1200 bit/s at 50 MHz). Legal range ≥ 8.
- HALF_CYCLES, BIT_CYCLES/2, sample offset from the detected start edge to mid-bit.

Ports:
- CLK_50M  input  1  system clock, 50 MHz.
- reset  input  1  synchronous, active-high reset.
- IRDA_RXD  input  1  asynchronous demodulator output; active-low: 0 = carrier present (mark), 1 = no carrier (space).
- Dout  output  8  last correctly received byte.
- data_valid  output  1  one-cycle pulse when Dout is updated.
- frame_err  output  1  one-cycle pulse on stop-bit violation.
- busy  output  1  high while a frame is being decoded (any state other than IDLE).

Behaviour:
- Input conditioning:
  - IRDA_RXD passes through a 2-FF synchroniser clocked by CLK_50M.
  - mark = NOT synchronised value.
  - All timing below is relative to the synchronised signal.
- Frame, line idle = space:
  - 1 start bit (mark).
  - 8 data bits, LSB first; mark = 1, space = 0.
  - 1 stop bit (space).
  - Each bit lasts BIT_CYCLES.
- Single counter cnt, width clog2(BIT_CYCLES); bit index bidx, 3 bits; shift register sr, 8 bits.
- IDLE:
  - On the first cycle mark = 1: cnt ← 0, go to START.
  - busy goes high in the next cycle.
- START:
  - cnt increments each cycle.
  - When cnt = HALF_CYCLES-1, sample mark:
    - mark = 1: cnt ← 0, bidx ← 0, go to DATA.
    - mark = 0: glitch; go to IDLE with no output pulses.
- DATA:
  - cnt increments each cycle.
  - When cnt = BIT_CYCLES-1 (mid-bit): sr ← {mark, sr[7:1]}, cnt ← 0.
  - If bidx = 7, go to STOP; else bidx ← bidx+1.
- STOP:
  - When cnt = BIT_CYCLES-1, sample mark:
    - mark = 0: next cycle Dout ← sr, data_valid = 1 for exactly that cycle; go to IDLE.
    - mark = 1: next cycle frame_err = 1 for one cycle; Dout unchanged, no data_valid; go to WAIT_IDLE.
- WAIT_IDLE:
  - Stay until mark = 0 for one cycle, then go to IDLE.
  - Prevents re-triggering inside a stuck-mark condition.
- Latency: data_valid rises 2 (sync) + HALF_CYCLES + 9·BIT_CYCLES + 1 cycles after the IRDA_RXD falling edge of the start bit (±1 cycle of sampling phase).
- Back-to-back frames:
  - Returning to IDLE at mid-stop-bit leaves HALF_CYCLES of stop bit.
  - A next start edge arriving at the nominal stop-bit end is accepted.
- Dout holds its value until the next good frame. No overrun flag: the consumer must take Dout within one frame time.
- Reset, synchronous, any state, including mid-frame:
  - State ← IDLE; cnt, bidx, sr ← 0.
  - Dout ← 8'h00; data_valid, frame_err, busy ← 0.
  - Synchroniser flops ← 1 (space).
  - A frame in progress at reset is discarded.
- data_valid and frame_err are never high in the same cycle.

Test Plan:
- BIT_CYCLES = 16 for all scenarios.
- Send frame 0xA5 with a correct stop bit → Dout = 8'hA5; data_valid high exactly 1 cycle, about 2+8+144+1 cycles after the start edge; frame_err stays 0; busy high throughout, then low.
- Two back-to-back frames 0x00 then 0xFF, no idle gap → two data_valid pulses; Dout = 8'h00 then 8'hFF.
- Mark glitch of 4 cycles on an idle line → no data_valid, no frame_err; busy returns 0 after HALF_CYCLES; Dout unchanged.
- Frame 0x3C with the stop bit held as mark for 40 cycles → frame_err one pulse; Dout retains the previous value; no new frame is accepted until the line returns to space, then frame 0x81 decodes correctly.
- Assert reset during data bit 4 of frame 0x5A → all outputs 0 next cycle, no pulses; a subsequent frame 0x5A decodes correctly.
- Data pattern LSB-first check with 0x01 and 0x80 → Dout = 8'h01 and 8'h80, confirming bit order.
